cam_frame_counter: RTL and testbench

CAM_FRAME_COUNTER -- requirements
Module: cam_frame_counter

---
 rtl/cam_frame_counter.sv | 112 +++++++++++
 tb/tb_cam_frame_counter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_frame_counter.sv
`default_nettype none
// cam_frame_counter: counts camera frames by their HREF line total between VSYNC
// pulses and reports completed frames as valid (done) or wrong-length (err).
module cam_frame_counter #(
  parameter int unsigned EXP_LINES = 480,
  parameter bit          VSYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        cam_vsync,
  input  logic        cam_href,
  output logic [7:0]  frame_num,
  output logic [11:0] line_count,
  output logic        frame_done,
  output logic        frame_err
);

  localparam logic [11:0] C_EXP_LINES = 12'(EXP_LINES);
  localparam logic [11:0] C_LINE_MAX  = 12'hFFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SYNC   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t      state_q;
  logic [2:0]  vs_sync_q;
  logic [2:0]  hr_sync_q;
  logic [11:0] line_cnt_q;
  logic [11:0] line_cnt_d;
  logic [7:0]  frame_num_q;
  logic [11:0] line_count_q;
  logic        frame_done_q;
  logic        frame_err_q;

  logic vs_act;
  logic vs_act_prev;
  logic vs_rise;
  logic vs_fall;
  logic hr_rise;

  // Bits [0] and [1] synchronize; bit [2] is the previous synchronized sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_sync_q <= {3{~VSYNC_POL}};
      hr_sync_q <= 3'b000;
    end else begin
      vs_sync_q <= {vs_sync_q[1:0], cam_vsync};
      hr_sync_q <= {hr_sync_q[1:0], cam_href};
    end
  end

  assign vs_act      = (vs_sync_q[1] == VSYNC_POL);
  assign vs_act_prev = (vs_sync_q[2] == VSYNC_POL);
  assign vs_rise     = vs_act & ~vs_act_prev;
  assign vs_fall     = ~vs_act & vs_act_prev;
  assign hr_rise     = hr_sync_q[1] & ~hr_sync_q[2];

  assign line_cnt_d = (line_cnt_q == C_LINE_MAX) ? line_cnt_q : line_cnt_q + 12'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      line_cnt_q   <= 12'd0;
      frame_num_q  <= 8'd0;
      line_count_q <= 12'd0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (!enable) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (vs_rise) state_q <= S_SYNC;
          end
          S_SYNC: begin
            line_cnt_q <= 12'd0;
            if (vs_fall) state_q <= S_ACTIVE;
          end
          S_ACTIVE: begin
            // A frame-ending VSYNC edge wins over an HREF edge in the same cycle.
            if (vs_rise) begin
              line_count_q <= line_cnt_q;
              if (line_cnt_q == C_EXP_LINES) begin
                frame_done_q <= 1'b1;
                frame_num_q  <= frame_num_q + 8'd1;
              end else begin
                frame_err_q <= 1'b1;
              end
              state_q <= S_SYNC;
            end else if (hr_rise) begin
              line_cnt_q <= line_cnt_d;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign frame_num  = frame_num_q;
  assign line_count = line_count_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_frame_counter.sv
`default_nettype none
// tb_cam_frame_counter: two instances (480 lines active-high, 4 lines active-low VSYNC)
// driven by identical camera timing and checked against a frame-level model.
module tb_cam_frame_counter;

  localparam int C_EXP_A = 480;
  localparam int C_EXP_B = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        vs;
  logic        hr;
  logic        vs_b;
  logic [7:0]  fn_a, fn_b;
  logic [11:0] lc_a, lc_b;
  logic        done_a, done_b, err_a, err_b;

  assign vs_b = ~vs;

  always #5 clk = ~clk;

  cam_frame_counter #(.EXP_LINES(C_EXP_A), .VSYNC_POL(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cam_vsync(vs), .cam_href(hr),
    .frame_num(fn_a), .line_count(lc_a), .frame_done(done_a), .frame_err(err_a)
  );

  cam_frame_counter #(.EXP_LINES(C_EXP_B), .VSYNC_POL(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cam_vsync(vs_b), .cam_href(hr),
    .frame_num(fn_b), .line_count(lc_b), .frame_done(done_b), .frame_err(err_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse counters observed on the DUT outputs.
  int act_done_a = 0, act_err_a = 0, act_done_b = 0, act_err_b = 0, n_both = 0;
  always @(negedge clk) begin
    if (done_a) act_done_a++;
    if (err_a)  act_err_a++;
    if (done_b) act_done_b++;
    if (err_b)  act_err_b++;
    if ((done_a && err_a) || (done_b && err_b)) n_both++;
  end

  // Frame-level reference model: index 0 = instance A, 1 = instance B.
  int m_fn[2], m_lc[2], m_done[2], m_err[2];
  bit m_armed;

  function automatic int exp_of(input int i);
    return (i == 0) ? C_EXP_A : C_EXP_B;
  endfunction

  task automatic m_end(input int n);
    int lc;
    if (m_armed) begin
      lc = (n > 4095) ? 4095 : n;
      for (int i = 0; i < 2; i++) begin
        m_lc[i] = lc;
        if (lc == exp_of(i)) begin
          m_fn[i] = (m_fn[i] + 1) % 256;
          m_done[i]++;
        end else begin
          m_err[i]++;
        end
      end
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_fn[i] = 0;
      m_lc[i] = 0;
    end
    m_armed = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "/fn_a"},   32'(fn_a),  m_fn[0]);
    chk({tag, "/lc_a"},   32'(lc_a),  m_lc[0]);
    chk({tag, "/done_a"}, act_done_a, m_done[0]);
    chk({tag, "/err_a"},  act_err_a,  m_err[0]);
    chk({tag, "/fn_b"},   32'(fn_b),  m_fn[1]);
    chk({tag, "/lc_b"},   32'(lc_b),  m_lc[1]);
    chk({tag, "/done_b"}, act_done_b, m_done[1]);
    chk({tag, "/err_b"},  act_err_b,  m_err[1]);
  endtask

  // All stimulus tasks start and end just after a falling clock edge.
  task automatic run_lines(input int n, input bit fast);
    for (int i = 0; i < n; i++) begin
      int h = fast ? 1 : int'($urandom_range(1, 2));
      int l = fast ? 1 : int'($urandom_range(1, 2));
      hr = 1'b1;
      repeat (h) @(negedge clk);
      hr = 1'b0;
      repeat (l) @(negedge clk);
    end
  endtask

  task automatic boundary(input int n, input bit hr_same);
    m_end(n);
    vs = 1'b1;
    if (hr_same) hr = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    vs = 1'b0;
    hr = 1'b0;
    repeat (4) @(negedge clk);
    m_armed = enable;
  endtask

  task automatic drop_enable();
    enable  = 1'b0;
    m_armed = 1'b0;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame(input int n, input int drop_at, input bit hr_same, input bit fast);
    if (drop_at >= 0) begin
      run_lines(drop_at, fast);
      drop_enable();
      run_lines(n - drop_at, fast);
    end else begin
      run_lines(n, fast);
    end
    boundary(n, hr_same);
  endtask

  typedef struct {
    int lines;
    int drop_at;
    bit hr_same;
    int fn_a;
    int lc_a;
    int fn_b;
    int done_a;
    int err_a;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{480, -1, 1'b0, 1, 480, 0, 1, 0};
    vecs[1] = '{480, -1, 1'b0, 2, 480, 0, 2, 0};
    vecs[2] = '{480, -1, 1'b0, 3, 480, 0, 3, 0};
    vecs[3] = '{479, -1, 1'b0, 3, 479, 0, 3, 1};
    vecs[4] = '{481, -1, 1'b0, 3, 481, 0, 3, 2};
    vecs[5] = '{480, -1, 1'b1, 4, 480, 0, 4, 2};
    vecs[6] = '{4,   -1, 1'b0, 4, 4,   1, 4, 3};
    vecs[7] = '{480, 200, 1'b0, 4, 4,  1, 4, 3};
    vecs[8] = '{480, -1, 1'b0, 5, 480, 1, 5, 3};
    vecs[9] = '{0,   -1, 1'b0, 5, 0,   1, 5, 4};

    for (int i = 0; i < 2; i++) begin
      m_done[i] = 0;
      m_err[i]  = 0;
    end
    m_reset();

    reset_n = 1'b0;
    enable  = 1'b0;
    vs      = 1'b0;
    hr      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst/fn_a", 32'(fn_a), 0);
    chk("rst/lc_a", 32'(lc_a), 0);
    chk("rst/done_a", 32'(done_a), 0);
    chk("rst/err_a", 32'(err_a), 0);
    chk("rst/fn_b", 32'(fn_b), 0);
    chk("rst/lc_b", 32'(lc_b), 0);

    reset_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    boundary(0, 1'b0);
    check_model("open");

    for (int i = 0; i < 10; i++) begin
      frame(vecs[i].lines, vecs[i].drop_at, vecs[i].hr_same, 1'b0);
      chk($sformatf("vec%0d/fn_a", i), 32'(fn_a), vecs[i].fn_a);
      chk($sformatf("vec%0d/lc_a", i), 32'(lc_a), vecs[i].lc_a);
      chk($sformatf("vec%0d/fn_b", i), 32'(fn_b), vecs[i].fn_b);
      chk($sformatf("vec%0d/done_a", i), act_done_a, vecs[i].done_a);
      chk($sformatf("vec%0d/err_a", i), act_err_a, vecs[i].err_a);
      check_model($sformatf("vec%0d", i));
    end

    // Output latency: VSYNC set at a falling edge; E1 samples it, results after E3.
    run_lines(480, 1'b0);
    m_end(480);
    vs = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("lat_e2/done_a", 32'(done_a), 0);
    chk("lat_e2/fn_a", 32'(fn_a), 5);
    @(posedge clk);
    #1;
    chk("lat_e3/done_a", 32'(done_a), 1);
    chk("lat_e3/err_b", 32'(err_b), 1);
    chk("lat_e3/fn_a", 32'(fn_a), 6);
    chk("lat_e3/lc_b", 32'(lc_b), 480);
    @(posedge clk);
    #1;
    chk("lat_e4/done_a", 32'(done_a), 0);
    @(negedge clk);
    vs = 1'b0;
    repeat (4) @(negedge clk);
    m_armed = enable;
    check_model("lat");

    // Asynchronous reset in the middle of a frame.
    run_lines(300, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst/fn_a", 32'(fn_a), 0);
    chk("arst/lc_a", 32'(lc_a), 0);
    chk("arst/fn_b", 32'(fn_b), 0);
    chk("arst/lc_b", 32'(lc_b), 0);
    m_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    boundary(0, 1'b0);
    frame(480, -1, 1'b0, 1'b0);
    chk("arst_next/fn_a", 32'(fn_a), 1);
    chk("arst_next/lc_a", 32'(lc_a), 480);
    check_model("arst_next");

    // frame_num wrap on instance B (4-line frames).
    for (int i = 0; i < 255; i++) begin
      frame(4, -1, 1'b0, 1'b1);
      check_model("wrap_fill");
    end
    chk("wrap/fn_b_255", 32'(fn_b), 255);
    frame(4, -1, 1'b0, 1'b1);
    chk("wrap/fn_b_0", 32'(fn_b), 0);
    check_model("wrap");

    // Line counter saturates at 4095.
    frame(4100, -1, 1'b0, 1'b1);
    chk("sat/lc_a", 32'(lc_a), 4095);
    check_model("sat");

    for (int f = 0; f < 12; f++) begin
      int n;
      int drop;
      case ($urandom_range(0, 3))
        0:       n = C_EXP_A;
        1:       n = C_EXP_B;
        2:       n = C_EXP_A - 1 + 2 * int'($urandom_range(0, 1));
        default: n = int'($urandom_range(0, 500));
      endcase
      drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n)) : -1;
      frame(n, drop, 1'($urandom_range(0, 1)), 1'b0);
      check_model($sformatf("rand%0d", f));
    end

    chk("never_both", n_both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
